response_capture_reg: RTL
=========================

Name: response_capture_reg

Overview:
Double-buffered capture register for DUT response pins, the read-back counterpart of the template drive registers. SAMPLE latches the DUT pin bus into a capture buffer. START transfers the buffer into a shift register, which is serialized LSB-first to the host-side readout logic over a valid/ready handshake. Sits between the DUT pin pads and the tester's readout path; sampling may proceed while a previous vector is still shifting out.

Parameters:
WIDTH, 16, number of DUT pins captured per vector (>= 2)
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous, active-low reset
DUT_IN  in  WIDTH  DUT response pins
SAMPLE  in  1  one-cycle strobe: capture DUT_IN into the buffer
START  in  1  one-cycle strobe: move buffer to shift register and begin serializing
CLR_OVR  in  1  clears OVERRUN
SOUT  out  1  serial data bit
SOUT_VALID  out  1  SOUT holds a valid bit
SOUT_READY  in  1  consumer accepts the bit when VALID & READY
SOUT_LAST  out  1  current SOUT bit is bit WIDTH-1
BUF_FULL  out  1  capture buffer holds a vector not yet transferred
BUSY  out  1  FSM is in SHIFT
DONE  out  1  one-cycle pulse after the last bit is accepted
OVERRUN  out  1  sticky: a SAMPLE was dropped

Behaviour:
- Reset (RST_N low, asynchronous): capture buffer, shift register, and bit counter all 0. SOUT, SOUT_VALID, SOUT_LAST, BUF_FULL, BUSY, DONE and OVERRUN are all 0. FSM enters IDLE. Reset mid-shift aborts the vector with no DONE pulse.
- SAMPLE with BUF_FULL=0: the buffer takes DUT_IN at this edge, and BUF_FULL=1 from the next cycle.
- SAMPLE with BUF_FULL=1 and no transfer this cycle: the new data is dropped, the buffer keeps the old vector, and OVERRUN=1 next cycle.
- OVERRUN stays set until CLR_OVR. CLR_OVR and a new overrun in the same cycle leaves OVERRUN=1 (set wins).
- FSM states: IDLE and SHIFT.
- IDLE:
  - SOUT_VALID=0, BUSY=0.
  - START with BUF_FULL=1: shreg <= buffer, count <= 0, BUF_FULL <= 0, go to SHIFT.
  - START with BUF_FULL=0: ignored, no state change.
- SHIFT:
  - BUSY=1, SOUT_VALID=1, SOUT=shreg[0], SOUT_LAST=(count==WIDTH-1).
  - On VALID & READY: shreg shifts right by 1 and count increments.
  - If the accepted bit had SOUT_LAST=1: go to IDLE, and DONE=1 for exactly the next cycle.
  - While READY=0, SOUT, SOUT_VALID and SOUT_LAST hold stable.
  - START in SHIFT is ignored; the buffer is not touched.
- Latency: the first bit is on SOUT in the cycle after the START edge. With READY held high, a vector takes WIDTH cycles; the next START is accepted in the DONE cycle.
- SAMPLE and START in the same cycle, in IDLE with BUF_FULL=1:
  - The old buffer moves to shreg and the new DUT_IN enters the buffer.
  - BUF_FULL stays 1 and OVERRUN is not set.
- SAMPLE and START in the same cycle, in IDLE with BUF_FULL=0: the sample is captured and START is ignored (START does not see same-cycle data).
- SAMPLE during SHIFT follows the normal buffer rules above (this is the double-buffer path).

Optional Feature:
INPUT_SYNC_EN
- Defined: DUT_IN passes through a 2-flop synchronizer (reset to 0) before the buffer. SAMPLE captures the value DUT_IN had 2 cycles before the strobe edge.
- Undefined: DUT_IN is captured directly at the SAMPLE edge, with zero added latency.
- All other behaviour is identical in both builds.

Test Plan:
- WIDTH=8, DUT_IN=0xA5, SAMPLE, then START, READY=1 -> SOUT sequence 1,0,1,0,0,1,0,1 over 8 cycles; SOUT_LAST only on the 8th bit; DONE pulses once; BUF_FULL 1->0 at START.
- Same vector with READY toggling 1,0,0,1,... -> no bit lost or duplicated; SOUT stable while READY=0; 8 accepted bits total.
- SAMPLE 0x3C, SAMPLE 0xFF (no START in between) -> OVERRUN=1; serialized data is 0x3C; CLR_OVR -> OVERRUN=0.
- Buffer holds 0x11; SAMPLE 0x22 and START in the same cycle -> shifts out 0x11; BUF_FULL stays 1; a second START after DONE shifts out 0x22; OVERRUN=0.
- RST_N low after 3 bits of 0xA5 -> all outputs 0 immediately; no DONE; START after release with empty buffer -> ignored, BUSY stays 0.
- INPUT_SYNC_EN build: DUT_IN changes 0x00->0x5A one cycle before SAMPLE -> captured 0x00. Changing 2 cycles before SAMPLE -> captured 0x5A.

Source files
------------

// File: rtl/response_capture_reg.sv
// Purpose : double-buffered capture of DUT response pins, serialized LSB-first to the readout path.
// Latency : first bit on SOUT the cycle after an accepted START; WIDTH cycles per vector with SOUT_READY high.
// Backpress: SOUT_READY low stalls the shifter with SOUT/SOUT_VALID/SOUT_LAST held; sampling continues meanwhile.
//
// Ports:
//   CLK, RST_N         clock (rising edge), asynchronous active-low reset
//   DUT_IN[WIDTH]      DUT response pins
//   SAMPLE             strobe: capture DUT_IN into the capture buffer
//   START              strobe: move a full buffer into the shift register and start serializing
//   CLR_OVR            clears the sticky OVERRUN flag (a same-cycle overrun wins)
//   SOUT/SOUT_VALID/SOUT_READY/SOUT_LAST  serial valid/ready stream, LAST marks bit WIDTH-1
//   BUF_FULL, BUSY, DONE, OVERRUN         status: buffer occupied, shifting, end-of-vector pulse, dropped sample
//
// Build option: define INPUT_SYNC_EN to put a 2-flop synchronizer (reset to 0) in front of the
// capture buffer; SAMPLE then captures the value DUT_IN had two cycles before the strobe edge.

module response_capture_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DUT_IN,
  input  logic             SAMPLE,
  input  logic             START,
  input  logic             CLR_OVR,
  output logic             SOUT,
  output logic             SOUT_VALID,
  input  logic             SOUT_READY,
  output logic             SOUT_LAST,
  output logic             BUF_FULL,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERRUN
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cap_dat;     // data presented to the capture buffer
  logic [WIDTH-1:0] buf_q;       // capture buffer
  logic [WIDTH-1:0] shreg_q;     // serializer, bit 0 is the bit on SOUT
  logic [CNT_W-1:0] count_q;     // index of the bit currently on SOUT
  logic             buf_full_q;
  logic             overrun_q;
  logic             done_q;

  logic             xfer;        // buffer -> shift register this cycle
  logic             bit_acc;     // SOUT bit handed off this cycle
  logic             last_acc;    // handed-off bit was the last of the vector
  logic             capture;     // buffer loads cap_dat this cycle
  logic             drop;        // SAMPLE lost because the buffer is occupied

  // ---------------------------------------------------------------------------
  // Optional input synchronizer
  // ---------------------------------------------------------------------------
`ifdef INPUT_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= DUT_IN;
      sync2_q <= sync1_q;
    end
  end

  assign cap_dat = sync2_q;
`else
  assign cap_dat = DUT_IN;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and stream outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    BUSY       = 1'b0;
    SOUT_VALID = 1'b0;
    SOUT       = 1'b0;
    SOUT_LAST  = 1'b0;
    xfer       = 1'b0;
    bit_acc    = 1'b0;
    last_acc   = 1'b0;

    case (state_q)
      IDLE: begin
        // START with an empty buffer is simply ignored.
        if (START && buf_full_q) begin
          xfer    = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        BUSY       = 1'b1;
        SOUT_VALID = 1'b1;
        SOUT       = shreg_q[0];
        SOUT_LAST  = (count_q == LAST_IDX);
        if (SOUT_READY) begin
          bit_acc = 1'b1;
          if (count_q == LAST_IDX) begin
            last_acc = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A transfer empties the buffer in the same edge, so a coincident SAMPLE
  // lands in it instead of being dropped.
  assign capture = SAMPLE && (!buf_full_q || xfer);
  assign drop    = SAMPLE && buf_full_q && !xfer;

  // ---------------------------------------------------------------------------
  // Capture buffer and its occupancy flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      if (capture) begin
        buf_q      <= cap_dat;
        buf_full_q <= 1'b1;
      end else if (xfer) begin
        buf_full_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shift register and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      if (xfer) begin
        shreg_q <= buf_q;
        count_q <= '0;
      end else if (bit_acc) begin
        shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
        count_q <= count_q + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Set has priority over clear so a drop is never lost.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (CLR_OVR) begin
        overrun_q <= 1'b0;
      end
      done_q <= last_acc;
    end
  end

  assign BUF_FULL = buf_full_q;
  assign DONE     = done_q;
  assign OVERRUN  = overrun_q;

endmodule
